// File: rtl/reg_writeback.sv
// Register-file writeback stage: a 4-entry result FIFO that drains one write per cycle.
// It also reports which source registers still have writes in flight.
module reg_writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid,
  output logic        inReady,
  input  logic [4:0]  inReg,
  input  logic [31:0] inData,
  input  logic        hold,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic        RegWrite,
  input  logic [4:0]  queryReg1,
  input  logic [4:0]  queryReg2,
  output logic        pending1,
  output logic        pending2,
  output logic [2:0]  count
);

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;

  // Writes to register 0 finish the handshake but are dropped.
  assign push       = inValid & inReady & (inReg != '0);
  assign pop        = ~hold & (count != '0);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // Control state and output stage; inReady tracks the post-edge occupancy so a full FIFO never passes through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      inReady   <= 1'b0;
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      count    <= count_next;
      inReady  <= (count_next != CNT_W'(DEPTH));
      RegWrite <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        writeReg  <= mem[rd_ptr].rd;
        writeData <= mem[rd_ptr].data;
      end
    end
  end

  // Payload storage; reset only needs to clear occupancy, not contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{rd: inReg, data: inData};
    end
  end

  // Hazard lookup over live FIFO slots plus the write currently being issued.
  always_comb begin
    pending1 = 1'b0;
    pending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (mem[rd_ptr + PTR_W'(i)].rd == queryReg1) pending1 = 1'b1;
        if (mem[rd_ptr + PTR_W'(i)].rd == queryReg2) pending2 = 1'b1;
      end
    end
    if (RegWrite && (writeReg == queryReg1)) pending1 = 1'b1;
    if (RegWrite && (writeReg == queryReg2)) pending2 = 1'b1;
    if (queryReg1 == '0) pending1 = 1'b0;
    if (queryReg2 == '0) pending2 = 1'b0;
  end

endmodule
